// File: rtl/a2d_sched.sv
// -----------------------------------------------------------------------------
// a2d_sched : round-robin scheduler for three A2D channels behind a shared SPI
// master. Each accepted request issues two SPI transactions with the same
// command word: the first starts the conversion on the selected channel, the
// second (after a one-cycle dead time) reads the result back. The 12-bit result
// is stored in the register of the channel the pointer selects, then the
// pointer moves on LFT -> RGHT -> BATT -> LFT.
//
// Parameters
//   LFT_CH, RGHT_CH, BATT_CH : A2D channel numbers of left/right load cell and
//                              battery.
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   nxt      in   conversion request
//   wrt      out  one-cycle start pulse to the SPI master
//   cmd      out  16-bit command word, held between wrt pulses
//   done     in   one-cycle SPI transaction-complete pulse
//   rd_data  in   SPI receive word, valid when done=1
//   lft_ld   out  latest left load-cell result
//   rght_ld  out  latest right load-cell result
//   batt     out  latest battery result
//   vld      out  one-cycle pulse after a result register updates
//   busy     out  high while a request is in progress
//   ovr      out  one-cycle pulse for every request cycle dropped while busy
// -----------------------------------------------------------------------------
module a2d_sched #(
    parameter logic [2:0] LFT_CH  = 3'd0,
    parameter logic [2:0] RGHT_CH = 3'd4,
    parameter logic [2:0] BATT_CH = 3'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        vld,
    output logic        busy,
    output logic        ovr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DEAD = 2'd2,
        READ = 2'd3
    } state_t;

    localparam logic [1:0] PTR_LFT  = 2'd0;
    localparam logic [1:0] PTR_RGHT = 2'd1;
    localparam logic [1:0] PTR_BATT = 2'd2;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic        vld_q, vld_d;
    logic        ovr_q, ovr_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic [11:0] batt_q, batt_d;

    // Pointer value 3 cannot be reached; it falls into the LFT default.
    function automatic logic [2:0] ptr_to_ch(input logic [1:0] p);
        case (p)
            PTR_RGHT: ptr_to_ch = RGHT_CH;
            PTR_BATT: ptr_to_ch = BATT_CH;
            default:  ptr_to_ch = LFT_CH;
        endcase
    endfunction

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        case (p)
            PTR_LFT:  ptr_next = PTR_RGHT;
            PTR_RGHT: ptr_next = PTR_BATT;
            default:  ptr_next = PTR_LFT;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        vld_d   = 1'b0;
        lft_d   = lft_q;
        rght_d  = rght_q;
        batt_d  = batt_q;
        // Any request seen outside IDLE is dropped, including the cycle in
        // which READ completes (the FSM is not yet back in IDLE).
        ovr_d   = nxt && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (nxt) begin
                    wrt_d   = 1'b1;
                    cmd_d   = {2'b00, ptr_to_ch(ptr_q), 11'h000};
                    state_d = CMD;
                end
            end
            CMD: begin
                // Data returned by the conversion-start transaction is unused.
                if (done) begin
                    state_d = DEAD;
                end
            end
            DEAD: begin
                // Fixed one-cycle gap; the read reuses the latched cmd.
                wrt_d   = 1'b1;
                state_d = READ;
            end
            READ: begin
                if (done) begin
                    case (ptr_q)
                        PTR_RGHT: rght_d = rd_data[11:0];
                        PTR_BATT: batt_d = rd_data[11:0];
                        default:  lft_d  = rd_data[11:0];
                    endcase
                    vld_d   = 1'b1;
                    ptr_d   = ptr_next(ptr_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PTR_LFT;
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            batt_q  <= 12'h000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            batt_q  <= batt_d;
        end
    end

    assign wrt     = wrt_q;
    assign cmd     = cmd_q;
    assign vld     = vld_q;
    assign ovr     = ovr_q;
    assign busy    = (state_q != IDLE);
    assign lft_ld  = lft_q;
    assign rght_ld = rght_q;
    assign batt    = batt_q;

endmodule

// File: tb/tb_a2d_sched.sv
// -----------------------------------------------------------------------------
// tb_a2d_sched : self-checking bench for a2d_sched. A transaction-level model
// (channel table, round-robin index, three result registers) predicts command
// words, stored results and pulse counts; an SPI responder inside the bench
// answers each wrt with done after a chosen latency.
// -----------------------------------------------------------------------------
module tb_a2d_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nxt;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        vld, busy, ovr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nxt_until = 0;
    int n_wrt = 0, n_vld = 0, n_ovr = 0;

    // Reference model state
    logic [2:0]  m_ch [3] = '{3'd0, 3'd4, 3'd5};
    logic [11:0] m_reg[3];
    int          m_idx;

    a2d_sched dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .nxt     (nxt),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .lft_ld  (lft_ld),
        .rght_ld (rght_ld),
        .batt    (batt),
        .vld     (vld),
        .busy    (busy),
        .ovr     (ovr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrt === 1'b1) n_wrt <= n_wrt + 1;
        if (vld === 1'b1) n_vld <= n_vld + 1;
        if (ovr === 1'b1) n_ovr <= n_ovr + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time exceeded, cyc=%0d required finish", cyc);
        $fatal(1);
    end

    // Move to the middle of the next cycle; outputs are stable here and
    // inputs set here are sampled at the following rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
        cyc = cyc + 1;
        nxt = (cyc < nxt_until);
    endtask

    function automatic void model_reset();
        m_idx = 0;
        for (int i = 0; i < 3; i++) m_reg[i] = 12'h000;
    endfunction

    function automatic logic [15:0] model_cmd();
        return {2'b00, m_ch[m_idx], 11'h000};
    endfunction

    function automatic void model_done(input logic [11:0] d);
        m_reg[m_idx] = d;
        m_idx = (m_idx + 1) % 3;
    endfunction

    // Drives one request and acts as the SPI master. Timing values are cycles
    // relative to the cycle nxt was first raised.
    task automatic run_txn(input logic [15:0] junk, input logic [15:0] rdw,
                           input int lat, input int hold, input bit dead_done,
                           input bit nxt_at_done,
                           output logic [15:0] c1, output logic [15:0] c2,
                           output int tw1, output int tw2, output int tv,
                           output bit tmo);
        int t0, n;
        tmo = 0; c1 = 16'hxxxx; c2 = 16'hxxxx; tw1 = -1; tw2 = -1; tv = -1;
        t0 = cyc;
        nxt_until = cyc + hold;
        nxt = 1'b1;
        n = 0;
        do begin tick(); n++; end while (wrt !== 1'b1 && n < 20);
        if (wrt !== 1'b1) begin tmo = 1; return; end
        c1 = cmd; tw1 = cyc - t0;
        repeat (lat) tick();
        done = 1'b1; rd_data = junk;
        tick();
        done = 1'b0; rd_data = 16'($urandom);
        if (dead_done) done = 1'b1;
        n = 0;
        do begin tick(); done = 1'b0; n++; end while (wrt !== 1'b1 && n < 20);
        if (wrt !== 1'b1) begin tmo = 1; return; end
        c2 = cmd; tw2 = cyc - t0;
        repeat (lat) tick();
        done = 1'b1; rd_data = rdw;
        if (nxt_at_done) nxt = 1'b1;
        tick();
        done = 1'b0; rd_data = 16'($urandom);
        n = 0;
        while (vld !== 1'b1 && n < 20) begin tick(); n++; end
        if (vld !== 1'b1) begin tmo = 1; return; end
        tv = cyc - t0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; nxt = 1'b0; done = 1'b0; rd_data = 16'h0;
        model_reset();
        repeat (3) tick();
        total++;
        if ({wrt, vld, ovr, busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got wrt/vld/ovr/busy=%b required 0000", {wrt, vld, ovr, busy});
        end
        total++;
        if (cmd !== 16'h0000) begin
            bad++; $display("FAIL reset_cmd: got %h required 0000", cmd);
        end
        total++;
        if ({lft_ld, rght_ld, batt} !== 36'h0) begin
            bad++; $display("FAIL reset_regs: got %h %h %h required 000 000 000", lft_ld, rght_ld, batt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [15:0] c1, c2; int tw1, tw2, tv, w0, v0, lat; bit tmo;
        lat = $urandom_range(1, 4);
        w0 = n_wrt; v0 = n_vld;
        run_txn(16'($urandom), 16'hFABC, lat, 1, 0, 0, c1, c2, tw1, tw2, tv, tmo);
        model_done(12'hABC);
        tick(); tick();
        total++;
        if (tmo) begin bad++; $display("FAIL single_timeout: handshake stalled, required completion"); end
        total++;
        if (c1 !== 16'h0000 || c2 !== 16'h0000) begin
            bad++; $display("FAIL single_cmd: got %h/%h required 0000/0000", c1, c2);
        end
        total++;
        if ({lft_ld, rght_ld, batt} !== 36'hABC000000) begin
            bad++; $display("FAIL single_regs: got %h %h %h required abc 000 000", lft_ld, rght_ld, batt);
        end
        total++;
        if (n_vld - v0 !== 1 || n_wrt - w0 !== 2) begin
            bad++; $display("FAIL single_pulses: got vld=%0d wrt=%0d required 1 and 2", n_vld - v0, n_wrt - w0);
        end
        total++;
        if (tw1 !== 1 || tw2 !== lat + 3 || tv !== 2 * lat + 4) begin
            bad++; $display("FAIL single_timing: got wrt@%0d,%0d vld@%0d required %0d,%0d,%0d", tw1, tw2, tv, 1, lat + 3, 2 * lat + 4);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] c1, c2; int tw1, tw2, tv; bit tmo;
        logic [11:0] dat [3] = '{12'h111, 12'h222, 12'h333};
        logic [15:0] exp_cmd [3] = '{16'h0000, 16'h2000, 16'h2800};
        // Bring the model and DUT back to a known LFT start.
        rst_n = 1'b0; tick(); rst_n = 1'b1; model_reset(); tick();
        for (int i = 0; i < 3; i++) begin
            run_txn(16'($urandom), {4'($urandom), dat[i]}, $urandom_range(1, 3), 1, 0, 0, c1, c2, tw1, tw2, tv, tmo);
            total++;
            if (tmo || c1 !== exp_cmd[i] || c2 !== exp_cmd[i] || c1 !== model_cmd()) begin
                bad++; $display("FAIL rr_cmd%0d: got %h/%h tmo=%0d required %h", i, c1, c2, tmo, exp_cmd[i]);
            end
            model_done(dat[i]);
        end
        tick();
        total++;
        if (lft_ld !== 12'h111 || rght_ld !== 12'h222 || batt !== 12'h333) begin
            bad++; $display("FAIL rr_regs: got %h %h %h required 111 222 333", lft_ld, rght_ld, batt);
        end
        run_txn(16'($urandom), 16'($urandom), 2, 1, 0, 0, c1, c2, tw1, tw2, tv, tmo);
        model_done(c2 === 16'h0000 ? lft_ld : 12'hxxx);
        total++;
        if (tmo || c1 !== 16'h0000 || c2 !== 16'h0000) begin
            bad++; $display("FAIL rr_wrap: got %h/%h tmo=%0d required 0000", c1, c2, tmo);
        end
        tick();
    endtask

    task automatic test_overrun();
        logic [15:0] c1, c2; int tw1, tw2, tv, w0, v0, o0; bit tmo;
        logic [15:0] exp; logic [11:0] d;
        // nxt held for 5 cycles: one accepted, four dropped.
        exp = model_cmd(); d = 12'($urandom);
        w0 = n_wrt; v0 = n_vld; o0 = n_ovr;
        run_txn(16'($urandom), {4'h0, d}, 1, 5, 0, 0, c1, c2, tw1, tw2, tv, tmo);
        model_done(d);
        tick(); tick();
        total++;
        if (tmo || n_wrt - w0 !== 2 || n_vld - v0 !== 1 || c1 !== exp) begin
            bad++; $display("FAIL ovr_single_txn: got wrt=%0d vld=%0d cmd=%h tmo=%0d required 2 1 %h", n_wrt - w0, n_vld - v0, c1, tmo, exp);
        end
        total++;
        if (n_ovr - o0 !== 4) begin
            bad++; $display("FAIL ovr_count: got %0d required 4", n_ovr - o0);
        end
        total++;
        if ({lft_ld, rght_ld, batt} !== {m_reg[0], m_reg[1], m_reg[2]}) begin
            bad++; $display("FAIL ovr_regs: got %h %h %h required %h %h %h", lft_ld, rght_ld, batt, m_reg[0], m_reg[1], m_reg[2]);
        end
        // nxt raised in the cycle READ completes: dropped, one ovr.
        exp = model_cmd(); d = 12'($urandom);
        w0 = n_wrt; o0 = n_ovr;
        run_txn(16'($urandom), {4'h0, d}, 2, 1, 0, 1, c1, c2, tw1, tw2, tv, tmo);
        model_done(d);
        tick(); tick(); tick();
        total++;
        if (tmo || n_ovr - o0 !== 1 || n_wrt - w0 !== 2 || busy !== 1'b0) begin
            bad++; $display("FAIL ovr_at_done: got ovr=%0d wrt=%0d busy=%b required 1 2 0", n_ovr - o0, n_wrt - w0, busy);
        end
        // Pointer advanced exactly once per serviced request.
        exp = model_cmd(); d = 12'($urandom);
        run_txn(16'($urandom), {4'h0, d}, 1, 1, 0, 0, c1, c2, tw1, tw2, tv, tmo);
        model_done(d);
        total++;
        if (tmo || c1 !== exp) begin
            bad++; $display("FAIL ovr_ptr: got %h required %h", c1, exp);
        end
        tick();
    endtask

    task automatic test_spurious_done();
        logic [15:0] c1, c2; int tw1, tw2, tv, w0, v0, lat; bit tmo;
        logic [15:0] exp; logic [11:0] d;
        w0 = n_wrt; v0 = n_vld;
        repeat (3) begin done = 1'b1; rd_data = 16'($urandom); tick(); end
        done = 1'b0;
        tick(); tick();
        total++;
        if (n_wrt - w0 !== 0 || n_vld - v0 !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_done: got wrt=%0d vld=%0d busy=%b required 0 0 0", n_wrt - w0, n_vld - v0, busy);
        end
        total++;
        if ({lft_ld, rght_ld, batt} !== {m_reg[0], m_reg[1], m_reg[2]}) begin
            bad++; $display("FAIL idle_done_regs: got %h %h %h required %h %h %h", lft_ld, rght_ld, batt, m_reg[0], m_reg[1], m_reg[2]);
        end
        exp = model_cmd(); d = 12'($urandom); lat = $urandom_range(1, 3);
        w0 = n_wrt; v0 = n_vld;
        run_txn(16'($urandom), {4'hF, d}, lat, 1, 1, 0, c1, c2, tw1, tw2, tv, tmo);
        model_done(d);
        tick(); tick();
        total++;
        if (tmo || tw2 - tw1 !== lat + 2 || n_wrt - w0 !== 2 || n_vld - v0 !== 1) begin
            bad++; $display("FAIL dead_done: got gap=%0d wrt=%0d vld=%0d tmo=%0d required %0d 2 1", tw2 - tw1, n_wrt - w0, n_vld - v0, tmo, lat + 2);
        end
        total++;
        if ({lft_ld, rght_ld, batt} !== {m_reg[0], m_reg[1], m_reg[2]} || c2 !== exp) begin
            bad++; $display("FAIL dead_done_regs: got %h %h %h cmd=%h required %h %h %h cmd=%h", lft_ld, rght_ld, batt, c2, m_reg[0], m_reg[1], m_reg[2], exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] c1, c2; int tw1, tw2, tv, w0, v0, o0, exp_ovr, hold, lat; bit tmo;
        logic [15:0] exp; logic [11:0] d;
        w0 = n_wrt; v0 = n_vld; o0 = n_ovr; exp_ovr = 0;
        for (int i = 0; i < 10; i++) begin
            exp = model_cmd();
            d = 12'($urandom_range(1, 4095));
            hold = $urandom_range(1, 4);
            lat = $urandom_range(1, 5);
            exp_ovr += hold - 1;
            run_txn(16'($urandom), {4'($urandom), d}, lat, hold, 0, 0, c1, c2, tw1, tw2, tv, tmo);
            model_done(d);
            total++;
            if (tmo || c1 !== exp || c2 !== exp || tv !== 2 * lat + 4 ||
                {lft_ld, rght_ld, batt} !== {m_reg[0], m_reg[1], m_reg[2]}) begin
                bad++; $display("FAIL b2b_txn%0d: got cmd=%h/%h vld@%0d regs=%h %h %h required cmd=%h vld@%0d regs=%h %h %h",
                                i, c1, c2, tv, lft_ld, rght_ld, batt, exp, 2 * lat + 4, m_reg[0], m_reg[1], m_reg[2]);
            end
        end
        tick(); tick();
        total++;
        if (n_wrt - w0 !== 20 || n_vld - v0 !== 10 || n_ovr - o0 !== exp_ovr) begin
            bad++; $display("FAIL b2b_pulses: got wrt=%0d vld=%0d ovr=%0d required 20 10 %0d", n_wrt - w0, n_vld - v0, n_ovr - o0, exp_ovr);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] c1, c2; int tw1, tw2, tv, n, v0; bit tmo; logic [11:0] d;
        // Make sure every result register holds a non-zero value first.
        for (int i = 0; i < 3; i++) begin
            d = 12'($urandom_range(1, 4095));
            run_txn(16'($urandom), {4'h0, d}, 1, 1, 0, 0, c1, c2, tw1, tw2, tv, tmo);
            model_done(d);
        end
        tick();
        nxt_until = cyc + 1; nxt = 1'b1;
        n = 0;
        do begin tick(); n++; end while (wrt !== 1'b1 && n < 20);
        tick();
        done = 1'b1; tick(); done = 1'b0;
        n = 0;
        do begin tick(); n++; end while (wrt !== 1'b1 && n < 20);
        tick();
        total++;
        if (busy !== 1'b1 || lft_ld === 12'h000 || rght_ld === 12'h000 || batt === 12'h000) begin
            bad++; $display("FAIL rstmid_setup: got busy=%b regs=%h %h %h required busy=1 non-zero regs", busy, lft_ld, rght_ld, batt);
        end
        v0 = n_vld;
        rst_n = 1'b0;
        #1;
        total++;
        if ({wrt, vld, ovr, busy} !== 4'b0000 || cmd !== 16'h0000 || {lft_ld, rght_ld, batt} !== 36'h0) begin
            bad++; $display("FAIL rstmid_async: got ctl=%b cmd=%h regs=%h %h %h required 0000 0000 000 000 000",
                            {wrt, vld, ovr, busy}, cmd, lft_ld, rght_ld, batt);
        end
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        done = 1'b1; rd_data = 16'($urandom);
        tick();
        done = 1'b0;
        tick(); tick();
        total++;
        if (n_vld - v0 !== 0 || busy !== 1'b0 || {lft_ld, rght_ld, batt} !== 36'h0) begin
            bad++; $display("FAIL rstmid_late_done: got vld=%0d busy=%b regs=%h %h %h required 0 0 000 000 000",
                            n_vld - v0, busy, lft_ld, rght_ld, batt);
        end
        d = 12'($urandom_range(1, 4095));
        run_txn(16'($urandom), {4'h0, d}, 1, 1, 0, 0, c1, c2, tw1, tw2, tv, tmo);
        model_done(d);
        total++;
        if (tmo || c1 !== 16'h0000 || lft_ld !== d || rght_ld !== 12'h000) begin
            bad++; $display("FAIL rstmid_restart: got cmd=%h lft=%h rght=%h required 0000 %h 000", c1, lft_ld, rght_ld, d);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_overrun();
        test_spurious_done();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/a2d_sched.md
A2D_SCHED -- requirements
Module: a2d_sched

Interface
REQ-001 SHALL have parameter LFT_CH, default 3'd0, the A2D channel of the left load cell.
REQ-002 SHALL have parameter RGHT_CH, default 3'd4, the A2D channel of the right load cell.
REQ-003 SHALL have parameter BATT_CH, default 3'd5, the A2D channel of the battery.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port nxt, input, 1, conversion request, sampled each clk.
REQ-007 SHALL have port wrt, output, 1, one-cycle start pulse to the shared SPI master.
REQ-008 SHALL have port cmd, output, 16, command word to the SPI master.
REQ-009 SHALL have port done, input, 1, one-cycle SPI transaction-complete pulse.
REQ-010 SHALL have port rd_data, input, 16, SPI receive word, valid in the cycle done=1.
REQ-011 SHALL have port lft_ld, output, 12, latest left load-cell result.
REQ-012 SHALL have port rght_ld, output, 12, latest right load-cell result.
REQ-013 SHALL have port batt, output, 12, latest battery result.
REQ-014 SHALL have port vld, output, 1, one-cycle pulse when a result register updates.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-016 SHALL have port ovr, output, 1, one-cycle pulse when nxt is dropped.

Function
REQ-017 SHALL implement FSM states IDLE, CMD, DEAD, READ.
REQ-018 SHALL hold a 2-bit round-robin pointer cycling LFT(0) -> RGHT(1) -> BATT(2) -> LFT; the value 3 is unreachable and SHALL decode as LFT.
REQ-019 SHALL, in IDLE with nxt=1, assert wrt for exactly one cycle, drive cmd = {2'b00, ch[2:0], 11'h000} with ch selected by the pointer, and enter CMD.
REQ-020 SHALL latch cmd when wrt asserts and hold it constant until the next wrt.
REQ-021 SHALL remain in CMD until done=1; rd_data in that cycle SHALL be ignored; the next state is DEAD.
REQ-022 SHALL stay in DEAD for exactly one cycle, then assert wrt for one cycle with unchanged cmd and enter READ.
REQ-023 SHALL, in READ with done=1, capture rd_data[11:0] into the register selected by the pointer, pulse vld in the following cycle, advance the pointer, and return to IDLE.
REQ-024 SHALL leave the two unselected result registers unchanged.
REQ-025 SHALL produce minimum latency from nxt to vld of: 1 cycle + SPI time (CMD) + 1 cycle (DEAD) + 1 cycle + SPI time (READ) + 1 cycle.
REQ-026 SHALL ignore nxt while busy=1 (no queuing) and pulse ovr for one cycle per dropped nxt cycle.
REQ-027 SHALL ignore done when in IDLE or DEAD, with no state or register change.
REQ-028 SHALL, when nxt=1 in the same cycle the FSM returns to IDLE, not accept it (busy is still high) and pulse ovr.
REQ-029 SHALL assert wrt only on the IDLE->CMD and DEAD->READ transitions.
REQ-030 SHALL have no timeout; the FSM waits indefinitely for done.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously force state IDLE, pointer LFT, wrt=0, cmd=16'h0000, vld=0, ovr=0, busy=0, lft_ld=rght_ld=batt=12'h000.
REQ-032 SHALL, on reset mid-transaction, abandon the transaction; a done arriving after reset release SHALL be ignored (REQ-027).
REQ-033 SHALL start the first request after reset release on LFT_CH.

Verification
REQ-034 Reset then nxt pulse, SPI model returns 16'hFABC on the second done -> cmd=16'h0000 on both wrt pulses, lft_ld=12'hABC, one vld pulse, rght_ld and batt remain 0.
REQ-035 Three serviced nxt requests returning 12'h111, 12'h222, 12'h333 -> cmds 16'h0000, 16'h2000, 16'h2800; lft_ld=111, rght_ld=222, batt=333; a fourth request issues 16'h0000 again.
REQ-036 nxt held high for 5 cycles while busy -> exactly one transaction; ovr pulses every busy cycle of nxt=1; the pointer advances once.
REQ-037 Spurious done in IDLE and in DEAD -> no wrt, no vld, registers unchanged; DEAD lasts exactly 1 cycle.
REQ-038 rst_n dropped in READ, then a late done -> all outputs are their reset values, no vld; the next nxt targets LFT_CH.
REQ-039 SPI model with 1-cycle done latency -> wrt pulses exactly 3 cycles apart and vld arrives 6 cycles after nxt.
